// File: rtl/vec_inst_issue_queue.sv
// Vector instruction issue queue: buffers scalar-issued vector instructions and
// their scalar operands until the vector datapath consumes them. Optional
// zero-latency bypass when the queue is empty.
module vec_inst_issue_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_OPS   = 2,
    parameter int unsigned BYPASS_EN = 1,
    parameter int unsigned AFULL_LVL = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inst_valid,
    input  logic [XLEN-1:0]         instruction,
    input  logic [NUM_OPS*XLEN-1:0] rs_data,
    output logic                    inst_ready,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [XLEN-1:0]         deq_instruction,
    output logic [NUM_OPS*XLEN-1:0] deq_rs_data,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = NUM_OPS * XLEN;

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [OW-1:0]   ops_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic bypass_on;
    logic enq, deq;
    logic pass_through;
    logic wr_en, rd_en;

    // Status flags come from registered count only
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        almost_full = (count_q >= CW'(AFULL_LVL));
        count       = count_q;
    end

    // Handshake and head presentation; bypass shows the offered word while empty
    always_comb begin
        bypass_on  = (BYPASS_EN != 0) && empty;
        inst_ready = !full && !flush && !reset;
        if (reset || flush) begin
            deq_valid = 1'b0;
        end else if (!empty) begin
            deq_valid = 1'b1;
        end else begin
            deq_valid = bypass_on && inst_valid;
        end
        if (bypass_on) begin
            deq_instruction = instruction;
            deq_rs_data     = rs_data;
        end else begin
            deq_instruction = inst_mem[rd_ptr_q];
            deq_rs_data     = ops_mem[rd_ptr_q];
        end
        enq          = inst_valid && inst_ready;
        deq          = deq_valid && deq_ready;
        // Consumed the same cycle it arrived at an empty queue: never stored
        pass_through = bypass_on && enq && deq;
        wr_en        = enq && !pass_through;
        rd_en        = deq && !empty;
    end

    // Next-state for pointers and occupancy; flush overrides any handshake
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Pointer and count state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            inst_mem[wr_ptr_q] <= instruction;
            ops_mem[wr_ptr_q]  <= rs_data;
        end
    end

endmodule

// File: tb/tb_vec_inst_issue_queue.sv
// Directed bench for vec_inst_issue_queue (DEPTH=4, two operands, XLEN=32),
// plus a second instance with the bypass disabled.
module tb_vec_inst_issue_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iv = 1'b0, dr = 1'b0, fl = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] rs = '0;
    logic        ir, dv, emp, ful, af;
    logic [31:0] dinst;
    logic [63:0] drs;
    logic [2:0]  cnt;

    logic        nb_iv = 1'b0, nb_dr = 1'b0;
    logic [31:0] nb_instr = '0;
    logic [63:0] nb_rs;
    logic        nb_ir, nb_dv, nb_emp, nb_ful, nb_af;
    logic [31:0] nb_dinst;
    logic [63:0] nb_drs;
    logic [2:0]  nb_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] ops(input logic [31:0] w);
        return {w ^ 32'hFFFF_0000, w + 32'd1};
    endfunction

    assign nb_rs = ops(nb_instr);

    vec_inst_issue_queue #(.XLEN(32), .DEPTH(4), .NUM_OPS(2), .BYPASS_EN(1)) dut (
        .clk(clk), .reset(reset), .inst_valid(iv), .instruction(instr), .rs_data(rs),
        .inst_ready(ir), .deq_valid(dv), .deq_ready(dr), .deq_instruction(dinst),
        .deq_rs_data(drs), .flush(fl), .count(cnt), .empty(emp), .full(ful),
        .almost_full(af)
    );

    vec_inst_issue_queue #(.XLEN(32), .DEPTH(4), .NUM_OPS(2), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .reset(reset), .inst_valid(nb_iv), .instruction(nb_instr),
        .rs_data(nb_rs), .inst_ready(nb_ir), .deq_valid(nb_dv), .deq_ready(nb_dr),
        .deq_instruction(nb_dinst), .deq_rs_data(nb_drs), .flush(1'b0), .count(nb_cnt),
        .empty(nb_emp), .full(nb_ful), .almost_full(nb_af)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
        iv    = v;
        instr = w;
        rs    = ops(w);
        dr    = r;
        fl    = f;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        dr;
        logic        fl;
        logic        dv;
        logic [31:0] dinst;
        logic [2:0]  cnt;
        logic        emp;
        logic        ful;
        logic        af;
        logic        ir;
    } vec_t;

    vec_t vecs[16];

    logic [31:0] sbq[$];
    logic [31:0] head;
    logic        e_ir, e_dv, e_enq, e_deq;
    int          sent, rcvd, cyc;

    initial begin
        // iv instr dr fl | dv dinst cnt emp ful af ir  (outputs before the edge)
        vecs[0]  = '{1, 32'h0000_5057, 1, 0, 1, 32'h0000_5057, 0, 1, 0, 0, 1}; // bypass
        vecs[1]  = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 1, 0, 0, 1};
        vecs[2]  = '{1, 32'hA,         0, 0, 1, 32'hA,         0, 1, 0, 0, 1}; // fill
        vecs[3]  = '{1, 32'hB,         0, 0, 1, 32'hA,         1, 0, 0, 0, 1};
        vecs[4]  = '{1, 32'hC,         0, 0, 1, 32'hA,         2, 0, 0, 0, 1};
        vecs[5]  = '{1, 32'hD,         0, 0, 1, 32'hA,         3, 0, 0, 1, 1};
        vecs[6]  = '{1, 32'hE,         1, 0, 1, 32'hA,         4, 0, 1, 1, 0}; // full+deq
        vecs[7]  = '{1, 32'hE,         0, 0, 1, 32'hB,         3, 0, 0, 1, 1};
        vecs[8]  = '{0, 32'h0,         1, 0, 1, 32'hB,         4, 0, 1, 1, 0}; // drain
        vecs[9]  = '{0, 32'h0,         1, 0, 1, 32'hC,         3, 0, 0, 1, 1};
        vecs[10] = '{1, 32'hF,         1, 0, 1, 32'hD,         2, 0, 0, 0, 1}; // simul
        vecs[11] = '{1, 32'h10,        1, 0, 1, 32'hE,         2, 0, 0, 0, 1};
        vecs[12] = '{1, 32'h11,        1, 0, 1, 32'hF,         2, 0, 0, 0, 1};
        vecs[13] = '{1, 32'h12,        0, 0, 1, 32'h10,        2, 0, 0, 0, 1};
        vecs[14] = '{1, 32'h13,        1, 1, 0, 32'h0,         3, 0, 0, 1, 0}; // flush
        vecs[15] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 1, 0, 0, 1};

        // Reset state, with an offer present to exercise the blocked bypass
        drive(1, 32'h77, 1, 0);
        #1;
        chk("rst_ready", {63'd0, ir}, 64'd0);
        chk("rst_dvalid", {63'd0, dv}, 64'd0);
        chk("rst_count", {61'd0, cnt}, 64'd0);
        chk("rst_flags", {61'd0, emp, ful, af}, 64'b100);
        drive(0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Bypass disabled: 1-cycle latency, never same-cycle visibility
        @(negedge clk);
        nb_iv = 1'b1; nb_instr = 32'hBEEF; nb_dr = 1'b1;
        #2;
        chk("nb_dvalid0", {63'd0, nb_dv}, 64'd0);
        chk("nb_ready0", {63'd0, nb_ir}, 64'd1);
        @(negedge clk);
        nb_iv = 1'b0; nb_dr = 1'b0;
        #2;
        chk("nb_dvalid1", {63'd0, nb_dv}, 64'd1);
        chk("nb_dinst1", {32'd0, nb_dinst}, 64'hBEEF);
        chk("nb_drs1", nb_drs, ops(32'hBEEF));
        chk("nb_count1", {61'd0, nb_cnt}, 64'd1);
        @(negedge clk);
        nb_dr = 1'b1;
        @(negedge clk);
        nb_dr = 1'b0;
        #2;
        chk("nb_drained", {62'd0, nb_emp, nb_dv}, 64'b10);

        // Table: bypass, fill/drain, simultaneous enq/deq, flush
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].instr, vecs[i].dr, vecs[i].fl);
            #2;
            chk($sformatf("v%0d_dvalid", i), {63'd0, dv}, {63'd0, vecs[i].dv});
            chk($sformatf("v%0d_count", i), {61'd0, cnt}, {61'd0, vecs[i].cnt});
            chk($sformatf("v%0d_flags", i), {61'd0, emp, ful, af},
                {61'd0, vecs[i].emp, vecs[i].ful, vecs[i].af});
            chk($sformatf("v%0d_ready", i), {63'd0, ir}, {63'd0, vecs[i].ir});
            if (vecs[i].dv) begin
                chk($sformatf("v%0d_dinst", i), {32'd0, dinst}, {32'd0, vecs[i].dinst});
                chk($sformatf("v%0d_drs", i), drs, ops(vecs[i].dinst));
            end
        end

        // Wrap-around: 10 instructions, deq_ready toggling, scoreboard order check
        sent = 0; rcvd = 0; cyc = 0;
        sbq.delete();
        while ((sent < 10 || sbq.size() != 0) && cyc < 80) begin
            @(negedge clk);
            drive(sent < 10, 32'h100 + sent, (cyc % 2) == 0, 0);
            #2;
            e_ir  = sbq.size() < 4;
            e_dv  = (sbq.size() > 0) || iv;
            head  = (sbq.size() > 0) ? sbq[0] : instr;
            chk($sformatf("w%0d_count", cyc), {61'd0, cnt}, 64'(sbq.size()));
            chk($sformatf("w%0d_ready", cyc), {63'd0, ir}, {63'd0, e_ir});
            chk($sformatf("w%0d_dvalid", cyc), {63'd0, dv}, {63'd0, e_dv});
            if (e_dv) chk($sformatf("w%0d_dinst", cyc), {32'd0, dinst}, {32'd0, head});
            e_enq = iv && e_ir;
            e_deq = e_dv && dr;
            if (e_deq) rcvd++;
            if (!(sbq.size() == 0 && e_enq && e_deq)) begin
                if (e_deq) void'(sbq.pop_front());
                if (e_enq) sbq.push_back(instr);
            end
            if (e_enq) sent++;
            cyc++;
        end
        chk("wrap_received", 64'(rcvd), 64'd10);

        // Asynchronous reset mid-operation with two stored entries
        @(negedge clk);
        drive(1, 32'h11, 0, 0);
        @(negedge clk);
        drive(1, 32'h22, 0, 0);
        @(negedge clk);
        drive(1, 32'h33, 1, 0);
        #2;
        chk("ar_count_pre", {61'd0, cnt}, 64'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_count", {61'd0, cnt}, 64'd0);
        chk("ar_flags", {61'd0, emp, ful, af}, 64'b100);
        chk("ar_ready", {63'd0, ir}, 64'd0);
        chk("ar_dvalid", {63'd0, dv}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 32'h0, 0, 0);
        @(negedge clk);
        drive(1, 32'h0000_5057, 1, 0);
        #2;
        chk("ar_bypass_dv", {63'd0, dv}, 64'd1);
        chk("ar_bypass_dinst", {32'd0, dinst}, 64'h5057);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #2;
        chk("ar_after_count", {61'd0, cnt}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vec_inst_issue_queue.md
VEC_INST_ISSUE_QUEUE -- requirements
Module: vec_inst_issue_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the width of the instruction and of each scalar operand.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of entries; power of 2, at least 2.
REQ-003 SHALL have parameter NUM_OPS, default 2, meaning the number of scalar operands per entry (rs1, rs2, ...); at least 1.
REQ-004 SHALL have parameter BYPASS_EN, default 1, meaning 1 enables the empty-queue combinational bypass.
REQ-005 SHALL have parameter AFULL_LVL, default DEPTH-1, meaning the almost_full threshold; range 1..DEPTH.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port inst_valid, input, 1: the scalar processor offers an instruction.
REQ-009 Port instruction, input, XLEN: the offered instruction word.
REQ-010 Port rs_data, input, NUM_OPS*XLEN: the scalar operands; operand k occupies bits [k*XLEN +: XLEN].
REQ-011 Port inst_ready, output, 1: the queue accepts an instruction this cycle.
REQ-012 Port deq_valid, output, 1: the head entry is presented to the vector datapath.
REQ-013 Port deq_ready, input, 1: the vector processor consumes the head this cycle.
REQ-014 Port deq_instruction, output, XLEN: the head instruction.
REQ-015 Port deq_rs_data, output, NUM_OPS*XLEN: the head operands, packed as in REQ-010.
REQ-016 Port flush, input, 1: synchronous discard of all entries.
REQ-017 Port count, output, $clog2(DEPTH)+1: the number of stored entries.
REQ-018 Ports empty, full and almost_full, output, 1 bit each: the status flags.

Function
REQ-019 An enqueue SHALL occur exactly when inst_valid && inst_ready at a rising edge.
- One entry written per handshake.
- A held inst_valid never causes a duplicate write.
REQ-020 A dequeue SHALL occur exactly when deq_valid && deq_ready at a rising edge.
REQ-021 inst_ready SHALL equal !full && !flush && !reset.
- Combinational; no dependence on deq_ready.
REQ-022 With the queue non-empty, deq_valid SHALL be 1 and deq_instruction/deq_rs_data SHALL be the oldest entry (FIFO order).
REQ-023 With the queue empty and BYPASS_EN=1:
- deq_valid SHALL equal inst_valid && !flush.
- deq outputs SHALL equal instruction/rs_data combinationally.
- If deq_ready is also 1, the entry SHALL NOT be stored and count SHALL stay 0 (zero-latency pass-through).
REQ-024 With the queue empty and BYPASS_EN=0:
- deq_valid SHALL be 0.
- An accepted instruction SHALL appear at deq the following cycle (1-cycle latency).
REQ-025 Simultaneous enqueue and dequeue while non-empty SHALL leave count unchanged, write at the tail and advance the head.
REQ-026 Full queue:
- inst_ready=0.
- A dequeue that cycle frees a slot visible from the next cycle only.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-028 Flags SHALL be registered-state derived: empty=(count==0), full=(count==DEPTH), almost_full=(count>=AFULL_LVL).
REQ-029 flush=1 at a rising edge:
- Pointers and count SHALL be set to 0.
- Any enqueue or dequeue that cycle SHALL be discarded.
- deq_valid SHALL be 0 during the flush cycle.
REQ-030 When empty and not bypassing, deq_instruction/deq_rs_data SHALL show the entry at the read pointer; their value is don't-care while deq_valid=0.

Reset
REQ-031 reset=1 SHALL asynchronously set pointers=0, count=0, empty=1, full=0 and almost_full=0.
REQ-032 While reset=1, inst_ready=0 and deq_valid=0, including the bypass path.
REQ-033 Storage array contents SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL drop all stored entries; the first handshake after reset release behaves as an empty queue.

Verification
REQ-035 Bypass (DEPTH=4, BYPASS_EN=1): empty queue, inst_valid=1, deq_ready=1, instruction=0x0000_5057 -> same cycle deq_valid=1, deq_instruction=0x0000_5057; count stays 0.
REQ-036 Fill and drain: deq_ready=0, enqueue instructions A, B, C, D -> count=4, full=1, inst_ready=0, almost_full=1 after C; then deq_ready=1 -> A, B, C, D in order over 4 cycles, then empty=1.
REQ-037 Wrap-around: 10 back-to-back instructions with deq_ready toggling 1,0,1,0 -> output order equals input order, count never exceeds 4, pointers wrap without loss.
REQ-038 Simultaneous enqueue/dequeue: count=2, inst_valid=1 and deq_ready=1 for 3 cycles -> count stays 2 and the head advances each cycle.
REQ-039 Flush: count=3, assert flush together with inst_valid=1 -> next cycle count=0, empty=1; the concurrent instruction is not stored; deq_valid=0 in the flush cycle.
REQ-040 Async reset: count=2, reset asserted between clock edges -> count=0, empty=1 and inst_ready=0 immediately; after release, the next instruction is handled per REQ-023.
